// File: rtl/pulse_sequencer.sv
// Output-side sequencer for the pg02 pulse generator: pulse and 256-bit PRBS modes,
// with shadowed configuration applied only at cycle/frame boundaries.
module pulse_sequencer #(
  parameter int unsigned PRBS_TICKS = 1,
  parameter logic [7:0]  SEED       = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [1:0]  cfg_mode,
  input  logic [15:0] cfg_tph,
  input  logic [15:0] cfg_tpl,
  input  logic        cfg_load,
  output logic        cfg_pending,
  output logic [1:0]  active_mode,
  output logic        signal_out,
  output logic        signal_cycle
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    LOW  = 2'b10,
    PRBS = 2'b11
  } state_e;

  localparam logic [7:0] PT_LAST = 8'(PRBS_TICKS - 32'd1);

  // De Bruijn-extended LFSR: the all-zero state is spliced in, giving period 256.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3] ^ (s[6:0] == 7'h00);
    return {s[6:0], fb};
  endfunction

  function automatic logic [14:0] phase_len(input logic [15:0] w);
    return (w[14:0] == 15'd0) ? 15'd1 : w[14:0];
  endfunction

  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? 2'b00 : m;
  endfunction

  state_e      state_q, state_d;
  logic [14:0] cnt_q, cnt_d;
  logic [7:0]  ptick_q, ptick_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [7:0]  bidx_q, bidx_d;
  logic [1:0]  act_mode_q, act_mode_d;
  logic [15:0] act_tph_q, act_tph_d;
  logic [15:0] act_tpl_q, act_tpl_d;
  logic [1:0]  sh_mode_q, sh_mode_d;
  logic [15:0] sh_tph_q, sh_tph_d;
  logic [15:0] sh_tpl_q, sh_tpl_d;
  logic        pending_q, pending_d;
  logic        sig_out_q, sig_out_d;
  logic        sig_cyc_q, sig_cyc_d;

  logic        boundary_s;
  logic [14:0] tph_last_s;
  logic [14:0] tpl_last_s;
  logic [1:0]  sel_mode_s;
  logic [15:0] sel_tph_s;
  logic [15:0] sel_tpl_s;

  assign tph_last_s = phase_len(act_tph_q) - 15'd1;
  assign tpl_last_s = phase_len(act_tpl_q) - 15'd1;

  // Boundary detection: IDLE always, else the last tick of a cycle or PRBS frame.
  always_comb begin
    boundary_s = 1'b0;
    case (state_q)
      IDLE: boundary_s = 1'b1;
      HIGH: begin
        if (tick && (cnt_q == tph_last_s) && !act_tpl_q[15]) begin
          boundary_s = 1'b1;
        end else begin
          boundary_s = 1'b0;
        end
      end
      LOW: begin
        if (tick && (cnt_q == tpl_last_s)) begin
          boundary_s = 1'b1;
        end else begin
          boundary_s = 1'b0;
        end
      end
      PRBS: begin
        if (tick && (ptick_q == PT_LAST) && (bidx_q == 8'hFF)) begin
          boundary_s = 1'b1;
        end else begin
          boundary_s = 1'b0;
        end
      end
      default: boundary_s = 1'b1;
    endcase
  end

  // Shadow capture and apply; a load on an applying edge re-arms pending.
  always_comb begin
    act_mode_d = act_mode_q;
    act_tph_d  = act_tph_q;
    act_tpl_d  = act_tpl_q;
    sh_mode_d  = sh_mode_q;
    sh_tph_d   = sh_tph_q;
    sh_tpl_d   = sh_tpl_q;
    pending_d  = pending_q;
    if (boundary_s && pending_q) begin
      sel_mode_s = sh_mode_q;
      sel_tph_s  = sh_tph_q;
      sel_tpl_s  = sh_tpl_q;
      act_mode_d = sh_mode_q;
      act_tph_d  = sh_tph_q;
      act_tpl_d  = sh_tpl_q;
      pending_d  = 1'b0;
    end else begin
      sel_mode_s = act_mode_q;
      sel_tph_s  = act_tph_q;
      sel_tpl_s  = act_tpl_q;
    end
    if (cfg_load) begin
      sh_mode_d = norm_mode(cfg_mode);
      sh_tph_d  = cfg_tph;
      sh_tpl_d  = cfg_tpl;
      pending_d = 1'b1;
    end else begin
      sh_mode_d = sh_mode_q;
    end
  end

  // Phase sequencing, PRBS stepping and next registered output values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptick_d   = ptick_q;
    lfsr_d    = lfsr_q;
    bidx_d    = bidx_q;
    sig_out_d = 1'b0;
    sig_cyc_d = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      HIGH: begin
        if (tick) begin
          if (cnt_q == tph_last_s) begin
            cnt_d = 15'd0;
            if (act_tpl_q[15]) begin
              state_d = LOW;
            end else begin
              state_d = HIGH;
            end
          end else begin
            cnt_d = cnt_q + 15'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      LOW: begin
        if (tick) begin
          if (cnt_q == tpl_last_s) begin
            cnt_d = 15'd0;
          end else begin
            cnt_d = cnt_q + 15'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      PRBS: begin
        if (tick) begin
          if (ptick_q == PT_LAST) begin
            ptick_d = 8'd0;
            lfsr_d  = lfsr_step(lfsr_q);
            bidx_d  = bidx_q + 8'd1;
          end else begin
            ptick_d = ptick_q + 8'd1;
          end
        end else begin
          ptick_d = ptick_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new cycle or frame always starts from the selected configuration.
    if (boundary_s) begin
      cnt_d   = 15'd0;
      ptick_d = 8'd0;
      case (sel_mode_s)
        2'b01: begin
          if (sel_tph_s[15]) begin
            state_d = HIGH;
          end else if (sel_tpl_s[15]) begin
            state_d = LOW;
          end else begin
            state_d = IDLE;
          end
        end
        2'b10: begin
          state_d = PRBS;
          lfsr_d  = SEED;
          bidx_d  = 8'd0;
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_d;
    end

    case (state_d)
      HIGH: begin
        sig_out_d = 1'b1;
        sig_cyc_d = 1'b1;
      end
      PRBS: begin
        sig_out_d = lfsr_d[7];
        sig_cyc_d = (bidx_d == 8'd0);
      end
      default: begin
        sig_out_d = 1'b0;
        sig_cyc_d = 1'b0;
      end
    endcase
  end

  // State, configuration and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 15'd0;
      ptick_q    <= 8'd0;
      lfsr_q     <= SEED;
      bidx_q     <= 8'd0;
      act_mode_q <= 2'b00;
      act_tph_q  <= 16'd0;
      act_tpl_q  <= 16'd0;
      sh_mode_q  <= 2'b00;
      sh_tph_q   <= 16'd0;
      sh_tpl_q   <= 16'd0;
      pending_q  <= 1'b0;
      sig_out_q  <= 1'b0;
      sig_cyc_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptick_q    <= ptick_d;
      lfsr_q     <= lfsr_d;
      bidx_q     <= bidx_d;
      act_mode_q <= act_mode_d;
      act_tph_q  <= act_tph_d;
      act_tpl_q  <= act_tpl_d;
      sh_mode_q  <= sh_mode_d;
      sh_tph_q   <= sh_tph_d;
      sh_tpl_q   <= sh_tpl_d;
      pending_q  <= pending_d;
      sig_out_q  <= sig_out_d;
      sig_cyc_q  <= sig_cyc_d;
    end
  end

  assign cfg_pending  = pending_q;
  assign active_mode  = act_mode_q;
  assign signal_out   = sig_out_q;
  assign signal_cycle = sig_cyc_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Bench for pulse_sequencer: a cycle-level model based on elapsed ticks per cycle/frame,
// checked every cycle, plus directed scenarios with hand-computed waveform literals.
module tb_pulse_sequencer;

  localparam int         PT = 1;
  localparam logic [7:0] SD = 8'h01;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b1;
  logic [1:0]  cfg_mode = 2'b00;
  logic [15:0] cfg_tph = 16'd0;
  logic [15:0] cfg_tpl = 16'd0;
  logic        cfg_load = 1'b0;
  logic        cfg_pending;
  logic [1:0]  active_mode;
  logic        signal_out;
  logic        signal_cycle;

  pulse_sequencer #(.PRBS_TICKS(PT), .SEED(SD)) dut (
    .clk(clk), .reset(reset), .tick(tick), .cfg_mode(cfg_mode),
    .cfg_tph(cfg_tph), .cfg_tpl(cfg_tpl), .cfg_load(cfg_load),
    .cfg_pending(cfg_pending), .active_mode(active_mode),
    .signal_out(signal_out), .signal_cycle(signal_cycle)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int tick_div = 1;
  int tick_ctr = 0;

  // model: active/shadow config and ticks elapsed in the current cycle or frame
  int          m_mode = 0;
  logic [15:0] m_tph = 16'd0;
  logic [15:0] m_tpl = 16'd0;
  int          sh_mode = 0;
  logic [15:0] sh_tph = 16'd0;
  logic [15:0] sh_tpl = 16'd0;
  bit          m_pend = 1'b0;
  int          m_el = 0;
  bit          prbs_bit [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int plen(input logic [15:0] w);
    if (!w[15]) return 0;
    if (w[14:0] == 15'd0) return 1;
    return int'(w[14:0]);
  endfunction

  function automatic int mperiod();
    if (m_mode == 1) return plen(m_tph) + plen(m_tpl);
    if (m_mode == 2) return 256 * PT;
    return 0;
  endfunction

  function automatic logic exp_out();
    if (m_mode == 1) return (m_el < plen(m_tph));
    if (m_mode == 2) return prbs_bit[(m_el / PT) % 256];
    return 1'b0;
  endfunction

  function automatic logic exp_cyc();
    if (m_mode == 1) return (m_el < plen(m_tph));
    if (m_mode == 2) return ((m_el / PT) == 0);
    return 1'b0;
  endfunction

  task automatic model_update();
    int p;
    bit bnd;
    if (reset) begin
      m_mode = 0; m_tph = 16'd0; m_tpl = 16'd0;
      sh_mode = 0; sh_tph = 16'd0; sh_tpl = 16'd0;
      m_pend = 1'b0; m_el = 0;
    end else begin
      p = mperiod();
      bnd = 1'b0;
      if (p == 0) bnd = 1'b1;
      else if (tick) begin
        m_el++;
        if (m_el >= p) bnd = 1'b1;
      end
      if (bnd) begin
        m_el = 0;
        if (m_pend) begin
          m_mode = sh_mode; m_tph = sh_tph; m_tpl = sh_tpl; m_pend = 1'b0;
        end
      end
      if (cfg_load) begin
        sh_mode = (cfg_mode == 2'b11) ? 0 : int'(cfg_mode);
        sh_tph = cfg_tph; sh_tpl = cfg_tpl; m_pend = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("signal_out", 32'(signal_out), 32'(exp_out()));
      chk("signal_cycle", 32'(signal_cycle), 32'(exp_cyc()));
      chk("active_mode", 32'(active_mode), 32'(m_mode));
      chk("cfg_pending", 32'(cfg_pending), 32'(m_pend));
    end
  end

  task automatic step();
    if (tick_div <= 1) tick = 1'b1;
    else tick = ((tick_ctr % tick_div) == 0);
    tick_ctr++;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic load(input logic [1:0] m, input logic [15:0] h, input logic [15:0] l);
    cfg_mode = m; cfg_tph = h; cfg_tpl = l; cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  task automatic wait_apply(input int maxc);
    int n;
    n = 0;
    while (cfg_pending === 1'b1 && n < maxc) begin
      step();
      n++;
    end
    chk("apply_wait", 32'(cfg_pending), 32'd0);
  endtask

  initial begin
    logic [7:0]   s;
    logic [15:0]  pat16;
    logic [11:0]  po, pp;
    logic [5:0]   pat6;
    logic [7:0]   pat8;
    logic [31:0]  pat32;
    logic [255:0] f0, f1;
    int ones, cyc_cnt, cyc_bad;

    // PRBS reference frame from the LFSR rule, pinned by literals
    s = SD;
    for (int i = 0; i < 256; i++) begin
      prbs_bit[i] = s[7];
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3] ^ (s[6:0] == 7'h00)};
    end
    chk("model_prbs_period", 32'(s), 32'(SD));
    ones = 0;
    for (int i = 0; i < 256; i++) ones += int'(prbs_bit[i]);
    chk("model_prbs_ones", 32'(ones), 32'd128);
    pat8 = 8'd0;
    for (int i = 0; i < 8; i++) pat8 = {pat8[6:0], prbs_bit[i]};
    chk("model_prbs_head", 32'(pat8), 32'h01);

    step(); step();
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_out", 32'(signal_out), 32'd0);
    chk("rst_pending", 32'(cfg_pending), 32'd0);

    // reset in the middle of HIGH
    load(2'b01, 16'h8003, 16'h8005);
    step(); step();
    chk("pre_rst_high", 32'(signal_out), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_out", 32'(signal_out), 32'd0);
    chk("midrst_cyc", 32'(signal_cycle), 32'd0);
    chk("midrst_mode", 32'(active_mode), 32'd0);
    chk("midrst_pend", 32'(cfg_pending), 32'd0);

    // pulse timing 3 high / 5 low
    load(2'b01, 16'h8003, 16'h8005);
    pat16 = 16'd0;
    for (int i = 0; i < 16; i++) begin
      step();
      pat16 = {pat16[14:0], signal_out};
    end
    chk("pulse_3_5", 32'(pat16), 32'h0000E0E0);

    // deferred update during HIGH
    step();
    load(2'b01, 16'h8001, 16'h8005);
    chk("defer_pend", 32'(cfg_pending), 32'd1);
    po = 12'd0; pp = 12'd0;
    for (int i = 0; i < 12; i++) begin
      step();
      po = {po[10:0], signal_out};
      pp = {pp[10:0], cfg_pending};
    end
    chk("defer_out", 32'(po), 32'h820);
    chk("defer_pend_seq", 32'(pp), 32'hFC0);

    // zero length and disabled phases
    load(2'b01, 16'h8000, 16'h8002);
    wait_apply(20);
    pat6 = 6'd0;
    for (int i = 0; i < 6; i++) begin
      pat6 = {pat6[4:0], signal_out};
      step();
    end
    chk("zero_len", 32'(pat6), 32'h24);
    load(2'b01, 16'h0003, 16'h8002);
    wait_apply(20);
    pat8 = 8'd0;
    for (int i = 0; i < 8; i++) begin
      pat8 = {pat8[6:0], signal_out};
      step();
    end
    chk("tph_disabled", 32'(pat8), 32'h00);
    load(2'b01, 16'h0000, 16'h0000);
    wait_apply(20);
    step(); step();
    chk("both_dis_mode", 32'(active_mode), 32'd1);
    chk("both_dis_out", 32'(signal_out), 32'd0);

    // PRBS: two full frames
    load(2'b10, 16'h0000, 16'h0000);
    wait_apply(10);
    cyc_cnt = 0; cyc_bad = 0;
    for (int i = 0; i < 512; i++) begin
      if (i < 256) f0[i] = signal_out;
      else f1[i - 256] = signal_out;
      if (signal_cycle) begin
        cyc_cnt++;
        if (i != 0 && i != 256) cyc_bad++;
      end
      if (i < 511) step();
    end
    chk("prbs_ones", 32'($countones(f0)), 32'd128);
    chk("prbs_cycles", 32'(cyc_cnt), 32'd2);
    chk("prbs_cycle_pos", 32'(cyc_bad), 32'd0);
    chk("prbs_repeat", 32'(f0 != f1), 32'd0);
    pat8 = 8'd0;
    for (int i = 0; i < 8; i++) pat8 = {pat8[6:0], f0[i]};
    chk("prbs_head", 32'(pat8), 32'h01);

    // off applied only at frame end
    step(); step(); step();
    load(2'b00, 16'h0000, 16'h0000);
    wait_apply(300);
    chk("off_mode", 32'(active_mode), 32'd0);

    // load on the applying edge: old shadow applied, new one pending
    load(2'b10, 16'h0000, 16'h0000);
    load(2'b01, 16'h8002, 16'h8002);
    chk("dbl_mode", 32'(active_mode), 32'd2);
    chk("dbl_pend", 32'(cfg_pending), 32'd1);
    wait_apply(300);
    chk("dbl_applied", 32'(active_mode), 32'd1);

    // tick every 4th clock: 2-tick phases last 8 clocks
    step(); step(); step();
    tick_div = 4;
    tick_ctr = 0;
    load(2'b01, 16'h8002, 16'h8002);
    wait_apply(60);
    pat32 = 32'd0;
    for (int i = 0; i < 32; i++) begin
      pat32 = {pat32[30:0], signal_out};
      step();
    end
    chk("tick_gate", pat32, 32'hFF00FF00);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_sequencer.md
# pulse_sequencer

Output-side controller for the pg02 pulse generator. It takes the mode and Tph/Tpl words produced by the user-interface FSM and sequences `signal_out` and `signal_cycle`. It supports a pulse mode and a 256-bit PRBS mode. Configuration changes are held in a shadow register and applied only at a cycle/frame boundary, so the output never shows a truncated phase.

## Interface

Parameters:
- `PRBS_TICKS`, default 1: ticks per PRBS bit, range 1..255.
- `SEED`, default 8'h01: LFSR value loaded at PRBS mode entry.

Ports:
- `clk`  in  1  system clock. One clock only.
- `reset`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-clk timebase enable. All phase timing counts ticks.
- `cfg_mode`  in  2  00 off, 01 pulse, 10 PRBS, 11 treated as off.
- `cfg_tph`  in  16  [15] enable, [14:0] high-phase length in ticks.
- `cfg_tpl`  in  16  [15] enable, [14:0] low-phase length in ticks.
- `cfg_load`  in  1  one-clk strobe; captures `cfg_*` into the shadow register.
- `cfg_pending`  out  1  shadow holds a capture not yet applied.
- `active_mode`  out  2  mode currently executing (00/01/10).
- `signal_out`  out  1  generated waveform, registered.
- `signal_cycle`  out  1  cycle/frame marker, registered.

## Operation

- State machine states: IDLE, HIGH, LOW, PRBS. Reset state is IDLE.
- Reset values: `signal_out`=0, `signal_cycle`=0, `active_mode`=00, `cfg_pending`=0.
- Reset values of internal registers: active and shadow regs = 0, LFSR = `SEED`, bit index = 0.
- Boundary = any of: IDLE, last tick of LOW, last tick of PRBS bit 255.
- Applying config: at a boundary with `cfg_pending`=1, copy shadow to active, clear pending, then enter the new mode's start state in the same clock.
- From IDLE, apply happens on the clock after `cfg_load`, without waiting for a tick.
- Pulse mode with both enables set:
  - HIGH lasts N=`tph[14:0]` ticks, then LOW lasts M=`tpl[14:0]` ticks, repeating.
  - A length of 0 is treated as 1.
  - `signal_out`=1 in HIGH, 0 in LOW. `signal_cycle`=1 in HIGH, 0 in LOW.
- Pulse mode with a single enable:
  - `tph` enable=0: `signal_out` stays 0; the sequencer still steps LOW only (boundary every M ticks).
  - `tpl` enable=0: `signal_out` stays 1; HIGH only (boundary every N ticks).
  - Both enables 0: behaves as IDLE; `active_mode` still reports 01.
- PRBS mode:
  - On entry: LFSR = `SEED`, bit index = 0.
  - Each bit lasts `PRBS_TICKS` ticks.
  - `signal_out` = LFSR[7].
  - On each bit advance: LFSR = {s[6:0], fb}, with fb = s[7]^s[5]^s[4]^s[3]^(s[6:0]==7'h00). This is a de Bruijn-extended LFSR with period exactly 256 and exactly 128 ones per frame.
  - Bit index is 8-bit and wraps 255 to 0.
  - `signal_cycle`=1 during bit index 0 only.
- Off mode (00/11): IDLE, both outputs 0.
- Mode change to off is applied at the next boundary. Off is itself a boundary state.
- A `cfg_load` while pending=1 overwrites the shadow (last write wins).
- `cfg_load` in the same clock as a boundary: the old shadow is applied and the new capture sets pending=1.
- `reset` asserted at any point, including mid-phase: all registers return to reset values on the next edge; any pending config is discarded.

## Timing

- Output latency: state change on a tick edge is visible on `signal_out`/`signal_cycle` in the same registered cycle. No extra pipeline stage.
- IDLE to first HIGH: the edge after `cfg_load` sets `signal_out`=1. The HIGH count starts from the next tick.
- Phase length: exactly N ticks. With `tick` tied high, HIGH = N clks and LOW = M clks.
- `cfg_pending` rises one clk after `cfg_load` and falls on the boundary edge that applies it.
- `tick`=0 freezes all counters and the LFSR. Outputs hold.

## Test plan

1. Reset: assert `reset` mid-HIGH with `tick` tied 1 -> next edge gives `signal_out`=0, `signal_cycle`=0, `active_mode`=00, `cfg_pending`=0.
2. Pulse timing: `tick`=1, load mode 01, tph=16'h8003, tpl=16'h8005 -> `signal_out` is 1 for 3 clks then 0 for 5 clks, period 8; `signal_cycle` equals `signal_out`.
3. Deferred update: while in HIGH of scenario 2, load tph=16'h8001 -> `cfg_pending`=1 until the end of the current LOW; the next HIGH lasts 1 clk.
4. Zero and disable: tph=16'h8000, tpl=16'h8002 -> HIGH 1 clk, LOW 2 clks. Then tph=16'h0003 -> `signal_out` constant 0.
5. PRBS: load mode 10 with `PRBS_TICKS`=1 -> `signal_cycle` pulses every 256 clks; exactly 128 ones per frame; the 256-bit sequence repeats identically.
6. Tick gating: pulse mode with `tick` asserted every 4th clk, tph=2, tpl=2 -> HIGH and LOW each last 8 clks; outputs hold while `tick`=0.
